// File: rtl/cell_pos_reader.sv
// Read-side controller for one cell position memory.
// On start it reads the particle count at address 0, then streams the
// {posz,posy,posx} words at addresses 1..N out over a valid/ready port.
// The memory is single-port with a fixed read latency. A small output FIFO
// absorbs consumer backpressure.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle request to stream the cell (ignored while busy)
//   busy, done      stream in progress / one-cycle completion pulse
//   particle_count  clamped count read from address 0
//   count_err       sticky: raw count exceeded PARTICLE_NUM-1 (cleared by start)
//   mem_addr/rden   registered memory read request; mem_wren is tied low
//   mem_q           memory read data, valid RD_LATENCY cycles after mem_rden
//   out_*           position word, source address, valid/ready handshake
//
// state    | meaning
// IDLE     | waiting for start
// RD_CNT   | issue the read of address 0 (particle count)
// WAIT_CNT | wait for the count word; latch it and issue address 1 if N>0
// STREAM   | issue addresses 2..N as buffer room allows
// DRAIN    | wait for in-flight reads and the FIFO to empty (also used when N=0)
// DONE     | pulse done for one cycle
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    generate
        if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_depth_check
            $error("cell_pos_reader: FIFO_DEPTH must be at least RD_LATENCY+1");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [RD_LATENCY-1:0] tag_v;
    logic [ADDR_WIDTH-1:0] tag_pid [RD_LATENCY];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pid  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_cnt, inflight, load;

    logic                  pop, push, cnt_arrive, room, cnt_over;
    logic [31:0]           raw_cnt;
    logic [ADDR_WIDTH-1:0] cnt_clamped;
    logic                  issue, latch_cnt, clr_err;
    logic [ADDR_WIDTH-1:0] issue_addr;

    assign mem_wren  = 1'b0;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_pid   = fifo_pid[rd_ptr];

    // Reads still on their way: the one being presented to memory plus every
    // tagged pipeline stage (the last stage is pushed at the coming edge).
    always_comb begin
        inflight = CW'(mem_rden);
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(tag_v[i]);
        end
    end

    assign pop        = out_valid && out_ready;
    assign push       = tag_v[RD_LATENCY-1] && (tag_pid[RD_LATENCY-1] != '0);
    assign cnt_arrive = tag_v[RD_LATENCY-1] && (tag_pid[RD_LATENCY-1] == '0);
    // Occupancy after this cycle's pop; crediting the pop keeps one word per
    // cycle with the consumer always ready, yet FIFO entries + reads in flight
    // never exceed FIFO_DEPTH.
    assign load = fifo_cnt + inflight - CW'(pop);
    assign room = (load < CW'(FIFO_DEPTH));

    assign raw_cnt     = mem_q[31:0];
    assign cnt_over    = (raw_cnt > 32'(PARTICLE_NUM - 1));
    assign cnt_clamped = cnt_over ? MAX_CNT : raw_cnt[ADDR_WIDTH-1:0];

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        issue_addr = next_addr;
        latch_cnt  = 1'b0;
        clr_err    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RD_CNT;
                    clr_err  = 1'b1;
                end
            end
            RD_CNT: begin
                issue      = 1'b1;
                issue_addr = '0;
                state_nx   = WAIT_CNT;
            end
            WAIT_CNT: begin
                if (cnt_arrive) begin
                    latch_cnt = 1'b1;
                    if (cnt_clamped == '0) begin
                        state_nx = DRAIN;
                    end else begin
                        // Issue address 1 straight from the count word so the
                        // stream starts without an idle cycle.
                        issue      = 1'b1;
                        issue_addr = ADDR_WIDTH'(1);
                        state_nx   = (cnt_clamped == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                    end
                end
            end
            STREAM: begin
                if (room) begin
                    issue = 1'b1;
                    if (next_addr == particle_count) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight == '0) &&
                    ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop))) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (start) begin
                    state_nx = RD_CNT;
                    clr_err  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem_rden       <= 1'b0;
            mem_addr       <= '0;
            next_addr      <= '0;
            particle_count <= '0;
            count_err      <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_rden <= issue;
            if (issue) begin
                mem_addr  <= issue_addr;
                next_addr <= issue_addr + ADDR_WIDTH'(1);
            end
            if (latch_cnt) particle_count <= cnt_clamped;
            if (clr_err) begin
                count_err <= 1'b0;
            end else if (latch_cnt && cnt_over) begin
                count_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag_pid[i] <= '0;
        end else begin
            tag_v      <= {tag_v[RD_LATENCY-2:0], mem_rden};
            tag_pid[0] <= mem_addr;
            for (int i = 1; i < RD_LATENCY; i++) tag_pid[i] <= tag_pid[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pid[i]  <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_q;
                fifo_pid[wr_ptr]  <= tag_pid[RD_LATENCY-1];
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_cell_pos_reader.sv
// Bench for cell_pos_reader: a behavioural memory with 2-cycle read latency,
// a scoreboard queue filled from the memory contents at start, and a monitor
// that checks every accepted word, output stability under stall, outstanding
// reads, issue order and done/busy timing.
module tb_cell_pos_reader;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic          busy, done, count_err, mem_rden, mem_wren, out_valid;
    logic [AW-1:0] particle_count, mem_addr, out_pid;
    logic [DW-1:0] mem_q, out_data, rd_p1;

    cell_pos_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .particle_count(particle_count), .count_err(count_err),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_q(mem_q), .out_data(out_data), .out_pid(out_pid),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem_arr [PN];
    always @(posedge clk) begin
        if (mem_rden) rd_p1 <= mem_arr[mem_addr];
        else          rd_p1 <= {3{32'hDEADBEEF}};
        mem_q <= rd_p1;
    end

    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    typedef struct packed {logic [AW-1:0] pid; logic [DW-1:0] data;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int total = 0, bad = 0;
    int exp_n = 0, next_exp_addr = 1;
    int issued, hs, done_cnt, rd0_cyc, rd1_cyc, first_v, last_hs, done_cyc;
    logic prev_stall = 1'b0, prev_busy = 1'b0;
    logic [AW-1:0] prev_pid;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_log();
        issued = 0; hs = 0; done_cnt = 0; rd0_cyc = -1; rd1_cyc = -1;
        first_v = -1; last_hs = -1; done_cyc = -1; next_exp_addr = 1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rden) begin
                if (mem_addr == '0) begin
                    rd0_cyc = cyc;
                end else begin
                    issued++;
                    if (mem_addr == AW'(1) && rd1_cyc < 0) rd1_cyc = cyc;
                    check("rden_order", mem_addr, next_exp_addr);
                    check("rden_not_past_n", next_exp_addr <= exp_n, 1);
                    next_exp_addr++;
                end
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (prev_stall) check("stall_stable", {out_valid, out_pid, out_data}, {1'b1, prev_pid, prev_data});
            if (out_valid && out_ready) begin
                hs++;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_word: got pid %0d expected no word", out_pid);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_pid", out_pid, mon_e.pid);
                    check("word_data", out_data, mon_e.data);
                end
            end
            check("outstanding_le4", (issued - hs) <= 4, 1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_with_done", busy, 0);
                check("busy_high_before_done", prev_busy, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_pid   = out_pid;
            prev_data  = out_data;
            prev_busy  = busy;
        end else begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end
    end

    task automatic run_cell(input int raw, input int mode, output int e0);
        mem_arr[0] = {$urandom, $urandom, 32'(raw)};
        for (int i = 1; i < PN; i++) mem_arr[i] = {$urandom, $urandom, $urandom};
        exp_n = (raw > PN - 1) ? PN - 1 : raw;
        exp_q.delete();
        for (int p = 1; p <= exp_n; p++) exp_q.push_back({AW'(p), mem_arr[p]});
        clear_log();
        ready_mode = mode;
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_seen", done_cnt != 0, 1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int e0;
    initial begin
        clear_log();
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rden", mem_rden, 0);
        check("rst_outputs", {particle_count, count_err, mem_addr, out_pid, out_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1: three words, consumer always ready
        run_cell(3, 0, e0);
        check("t1_busy_c0", busy, 1);
        wait_done(100);
        check("t1_rd0_cycle", rd0_cyc, e0 + 1);
        check("t1_rd1_cycle", rd1_cyc, e0 + 4);
        check("t1_first_valid", first_v, e0 + 7);
        check("t1_last_hs", last_hs, e0 + 9);
        check("t1_done_cycle", done_cyc, e0 + 10);
        check("t1_done_once", done_cnt, 1);
        check("t1_words", hs, 3);
        check("t1_count", particle_count, 3);
        check("t1_sb_empty", exp_q.size(), 0);

        // T2: empty cell
        run_cell(0, 0, e0);
        wait_done(100);
        check("t2_done_cycle", done_cyc, e0 + 5);
        check("t2_rd0_cycle", rd0_cyc, e0 + 1);
        check("t2_no_data_reads", issued, 0);
        check("t2_no_valid", first_v < 0, 1);
        check("t2_count", particle_count, 0);
        check("t2_err", count_err, 0);

        // T3: full cell, random backpressure
        run_cell(219, 1, e0);
        wait_done(3000);
        check("t3_words", hs, 219);
        check("t3_sb_empty", exp_q.size(), 0);
        check("t3_count", particle_count, 219);
        check("t3_err", count_err, 0);
        check("t3_done_once", done_cnt, 1);

        // T4: oversized raw count is clamped
        run_cell(500, 1, e0);
        wait_done(3000);
        check("t4_count", particle_count, 219);
        check("t4_err", count_err, 1);
        check("t4_words", hs, 219);
        check("t4_sb_empty", exp_q.size(), 0);

        // T5: start while busy is ignored; next start clears count_err
        run_cell(50, 1, e0);
        check("t5_err_cleared", count_err, 0);
        repeat (6) @(posedge clk);
        #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        wait_done(1500);
        check("t5_done_once", done_cnt, 1);
        check("t5_words", hs, 50);
        check("t5_sb_empty", exp_q.size(), 0);
        check("t5_count", particle_count, 50);

        // T5: reset mid-stream, then a clean restart
        run_cell(100, 0, e0);
        for (int n = 0; n < 200 && hs < 10; n++) begin
            @(negedge clk); #1;
        end
        check("t5_reached_stream", hs >= 10, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_rden", mem_rden, 0);
        check("t5_rst_outputs", {done, particle_count, count_err, mem_addr, out_pid, out_data}, 0);
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b1;
        run_cell(120, 1, e0);
        wait_done(2000);
        check("t5_restart_words", hs, 120);
        check("t5_restart_sb_empty", exp_q.size(), 0);
        check("t5_restart_count", particle_count, 120);

        // T6: consumer stalls for 20 cycles after first valid
        run_cell(10, 2, e0);
        for (int n = 0; n < 50 && first_v < 0; n++) begin
            @(negedge clk); #1;
        end
        check("t6_valid_seen", first_v >= 0, 1);
        repeat (20) @(negedge clk);
        #1;
        check("t6_issued_during_stall", issued, 4);
        check("t6_no_hs_during_stall", hs, 0);
        check("t6_head_pid", {out_valid, out_pid}, {1'b1, 8'd1});
        ready_mode = 0;
        wait_done(200);
        check("t6_words", hs, 10);
        check("t6_sb_empty", exp_q.size(), 0);
        check("mem_wren_low", mem_wren, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
